decode_stage_pipe: RTL and testbench

Pipelined, parametrised MIPS decode stage that sits between the fetch buffer and the execute stage. Each cycle it accepts one instruction and its PC over a valid/ready handshake, then decodes opcode and funct into a control bundle. The result is held in a registered ID/EX output with valid/ready backpressure. It detects load-use hazards and inserts a one-cycle bubble, supports flush, and flags illegal encodings.

---
 rtl/decode_stage_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// MIPS ID stage: decodes into a registered ID/EX bundle with load-use stall and flush.
// Define DECODE_EXT_OPS_EN to also decode ORI, SLT and BNE.
module decode_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int HAZARD_DET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_wr_reg,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_alu_src,
  output logic [3:0]      out_alu_ctr,
  output logic [XLEN-1:0] out_jump_target,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jt;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      wr_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic [3:0]      alu_ctr;
    logic            illegal;
  } id_ex_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1001;
  localparam logic [3:0] ALU_OR  = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [5:0] op;
  logic [5:0] fn;
  logic [XLEN-29:0] pc_hi;
  logic is_r, is_addi, is_andi, is_lw;
  logic is_sw, is_beq, is_j;
`ifdef DECODE_EXT_OPS_EN
  logic is_ori, is_bne;
`endif

  assign op      = in_instr[31:26];
  assign fn      = in_instr[5:0];
  assign pc_hi   = (XLEN-28)'((in_pc + XLEN'(4)) >> 28);
  assign is_r    = op == 6'b000000;
  assign is_addi = op == 6'b001000;
  assign is_andi = op == 6'b001100;
  assign is_lw   = op == 6'b100011;
  assign is_sw   = op == 6'b101011;
  assign is_beq  = op == 6'b000100;
  assign is_j    = op == 6'b000010;
`ifdef DECODE_EXT_OPS_EN
  assign is_ori  = op == 6'b001101;
  assign is_bne  = op == 6'b000101;
`endif

  id_ex_t dec;
  logic   uses_rs, uses_rt, reg_dst, sext;

  always_comb begin
    dec     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    reg_dst = 1'b0;
    sext    = 1'b1;
    dec.pc  = in_pc;
    dec.rs  = in_instr[25:21];
    dec.rt  = in_instr[20:16];
    dec.rd  = in_instr[15:11];
    dec.jt  = {pc_hi, in_instr[25:0], 2'b00};
    unique case (1'b1)
      is_r: begin
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        reg_dst       = 1'b1;
        dec.reg_write = 1'b1;
        unique case (fn)
          6'b100000,
          6'b100001: dec.alu_ctr = ALU_ADD;
          6'b100010: dec.alu_ctr = ALU_SUB;
          6'b100100: dec.alu_ctr = ALU_AND;
          6'b100101: dec.alu_ctr = ALU_OR;
          6'b100111: dec.alu_ctr = ALU_NOR;
`ifdef DECODE_EXT_OPS_EN
          6'b101010: dec.alu_ctr = ALU_SLT;
`endif
          default: begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
            uses_rs       = 1'b0;
            uses_rt       = 1'b0;
          end
        endcase
      end
      is_addi: begin
        uses_rs       = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_andi: begin
        uses_rs       = 1'b1;
        sext          = 1'b0;
        dec.alu_ctr   = ALU_AND;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
`ifdef DECODE_EXT_OPS_EN
      is_ori: begin
        uses_rs       = 1'b1;
        sext          = 1'b0;
        dec.alu_ctr   = ALU_OR;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_bne: begin
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
        dec.alu_ctr = ALU_SUB;
        dec.branch  = 1'b1;
      end
`endif
      is_lw: begin
        uses_rs       = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_sw: begin
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_beq: begin
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
        dec.alu_ctr = ALU_SUB;
        dec.branch  = 1'b1;
      end
      is_j: dec.jump = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = sext ? {{(XLEN-16){in_instr[15]}}, in_instr[15:0]}
                   : {{(XLEN-16){1'b0}}, in_instr[15:0]};
    dec.wr_reg = reg_dst ? dec.rd : dec.rt;
  end

  id_ex_t bundle_q, bundle_d;
  logic   valid_q, valid_d;
  logic   load, hazard, haz_hit;

  always_comb begin
    haz_hit = (bundle_q.wr_reg == in_instr[25:21] && uses_rs)
           || (bundle_q.wr_reg == in_instr[20:16] && uses_rt);
    hazard  = (HAZARD_DET != 0) && in_valid && valid_q
           && bundle_q.mem_read && (bundle_q.wr_reg != 5'd0) && haz_hit;
    load     = (!valid_q || out_ready) && !flush;
    in_ready = load && !hazard && !rst;
  end

  // bubbles keep stale fields but must never write anything
  always_comb begin
    bundle_d = bundle_q;
    valid_d  = valid_q;
    if (flush || (load && (hazard || !in_valid))) begin
      valid_d            = 1'b0;
      bundle_d.reg_write = 1'b0;
      bundle_d.mem_read  = 1'b0;
      bundle_d.mem_write = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = bundle_q.pc;
  assign out_imm         = bundle_q.imm;
  assign out_rs          = bundle_q.rs;
  assign out_rt          = bundle_q.rt;
  assign out_rd          = bundle_q.rd;
  assign out_wr_reg      = bundle_q.wr_reg;
  assign out_reg_write   = bundle_q.reg_write;
  assign out_mem_read    = bundle_q.mem_read;
  assign out_mem_write   = bundle_q.mem_write;
  assign out_branch      = bundle_q.branch;
  assign out_jump        = bundle_q.jump;
  assign out_alu_src     = bundle_q.alu_src;
  assign out_alu_ctr     = bundle_q.alu_ctr;
  assign out_jump_target = bundle_q.jt;
  assign out_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: instance 0 with load-use detection, instance 1 without,
// both fed the same stimulus and checked against a mnemonic-level model.
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready_w [2];
  logic        out_valid_w[2];
  logic [31:0] out_pc_w   [2];
  logic [31:0] out_imm_w  [2];
  logic [31:0] out_jt_w   [2];
  logic [4:0]  out_rs_w   [2];
  logic [4:0]  out_rt_w   [2];
  logic [4:0]  out_rd_w   [2];
  logic [4:0]  out_wr_w   [2];
  logic        rw_w [2];
  logic        mr_w [2];
  logic        mw_w [2];
  logic        br_w [2];
  logic        jp_w [2];
  logic        src_w[2];
  logic [3:0]  ctr_w[2];
  logic        ill_w[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage_pipe #(
      .XLEN(32),
      .HAZARD_DET(g == 0 ? 1 : 0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready_w[g]),
      .in_instr(in_instr),
      .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready),
      .out_pc(out_pc_w[g]),
      .out_imm(out_imm_w[g]),
      .out_rs(out_rs_w[g]),
      .out_rt(out_rt_w[g]),
      .out_rd(out_rd_w[g]),
      .out_wr_reg(out_wr_w[g]),
      .out_reg_write(rw_w[g]),
      .out_mem_read(mr_w[g]),
      .out_mem_write(mw_w[g]),
      .out_branch(br_w[g]),
      .out_jump(jp_w[g]),
      .out_alu_src(src_w[g]),
      .out_alu_ctr(ctr_w[g]),
      .out_jump_target(out_jt_w[g]),
      .out_illegal(ill_w[g])
    );
  end

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc, imm, jt;
    logic [4:0]  rs, rt, rd, wr;
    logic        rw, mr, mw, br, jp, src, ill;
    logic [3:0]  ctr;
    bit          u_rs, u_rt, c_imm, c_wr, c_ctr, c_src;
  } exp_t;

  exp_t m_ent  [2];
  bit   m_valid[2];

  function automatic string mnem(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    string mn = "ill";
    if (op == 6'h00) begin
      case (fn)
        6'h20: mn = "add";
        6'h21: mn = "addu";
        6'h22: mn = "sub";
        6'h24: mn = "and";
        6'h25: mn = "or";
        6'h27: mn = "nor";
`ifdef DECODE_EXT_OPS_EN
        6'h2a: mn = "slt";
`endif
        default: mn = "ill";
      endcase
    end else begin
      case (op)
        6'h08: mn = "addi";
        6'h0c: mn = "andi";
        6'h23: mn = "lw";
        6'h2b: mn = "sw";
        6'h04: mn = "beq";
        6'h02: mn = "j";
`ifdef DECODE_EXT_OPS_EN
        6'h0d: mn = "ori";
        6'h05: mn = "bne";
`endif
        default: mn = "ill";
      endcase
    end
    return mn;
  endfunction

  function automatic exp_t mdec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    bit r = 1'b0;
    string mn = mnem(ins);
    logic [31:0] se = 32'($signed(ins[15:0]));
    logic [31:0] ze = 32'(ins[15:0]);
    e = '{default: '0};
    e.pc = pc;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.rd = ins[15:11];
    e.jt = ((pc + 32'd4) & 32'hF000_0000) | {4'h0, ins[25:0], 2'b00};
    case (mn)
      "add", "addu": begin r = 1; e.ctr = 4'b0000; end
      "sub": begin r = 1; e.ctr = 4'b0001; end
      "and": begin r = 1; e.ctr = 4'b1001; end
      "or":  begin r = 1; e.ctr = 4'b1010; end
      "nor": begin r = 1; e.ctr = 4'b1100; end
      "slt": begin r = 1; e.ctr = 4'b0111; end
      "addi": begin e.ctr = 4'b0000; e.imm = se; e.rw = 1; e.src = 1; end
      "andi": begin e.ctr = 4'b1001; e.imm = ze; e.rw = 1; e.src = 1; end
      "ori":  begin e.ctr = 4'b1010; e.imm = ze; e.rw = 1; e.src = 1; end
      "lw": begin e.imm = se; e.mr = 1; e.rw = 1; e.src = 1; end
      "sw": begin e.imm = se; e.mw = 1; e.src = 1; end
      "beq", "bne": begin e.ctr = 4'b0001; e.imm = se; e.br = 1; end
      "j": e.jp = 1;
      default: e.ill = 1;
    endcase
    if (r) e.rw = 1;
    e.wr    = r ? e.rd : e.rt;
    e.u_rs  = !e.ill && mn != "j";
    e.u_rt  = r || mn == "sw" || mn == "beq" || mn == "bne";
    e.c_ctr = !e.ill;
    e.c_src = !e.ill && mn != "j";
    e.c_imm = !e.ill && !r && mn != "j";
    e.c_wr  = e.rw;
    return e;
  endfunction

  function automatic bit m_haz(input int k);
    exp_t d = mdec(in_instr, in_pc);
    if (k != 0) return 1'b0;
    return in_valid && m_valid[k] && m_ent[k].mr && m_ent[k].wr != 5'd0
        && ((m_ent[k].wr == d.rs && d.u_rs) || (m_ent[k].wr == d.rt && d.u_rt));
  endfunction

  function automatic bit m_ready(input int k);
    return !rst && (!m_valid[k] || out_ready) && !flush && !m_haz(k);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_valid[k] = 1'b0;
        m_ent[k]   = '{default: '0};
      end else if (flush || ((!m_valid[k] || out_ready) && (!in_valid || m_haz(k)))) begin
        m_valid[k]  = 1'b0;
        m_ent[k].rw = 1'b0;
        m_ent[k].mr = 1'b0;
        m_ent[k].mw = 1'b0;
      end else if (!m_valid[k] || out_ready) begin
        m_ent[k]   = mdec(in_instr, in_pc);
        m_valid[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.in_ready", k), 32'(in_ready_w[k]), 32'(m_ready(k)));
        chk($sformatf("u%0d.out_valid", k), 32'(out_valid_w[k]), 32'(m_valid[k]));
        chk($sformatf("u%0d.reg_write", k), 32'(rw_w[k]), 32'(m_ent[k].rw));
        chk($sformatf("u%0d.mem_read", k), 32'(mr_w[k]), 32'(m_ent[k].mr));
        chk($sformatf("u%0d.mem_write", k), 32'(mw_w[k]), 32'(m_ent[k].mw));
        if (m_valid[k]) begin
          chk($sformatf("u%0d.pc", k), out_pc_w[k], m_ent[k].pc);
          chk($sformatf("u%0d.rs", k), 32'(out_rs_w[k]), 32'(m_ent[k].rs));
          chk($sformatf("u%0d.rt", k), 32'(out_rt_w[k]), 32'(m_ent[k].rt));
          chk($sformatf("u%0d.rd", k), 32'(out_rd_w[k]), 32'(m_ent[k].rd));
          chk($sformatf("u%0d.jt", k), out_jt_w[k], m_ent[k].jt);
          chk($sformatf("u%0d.branch", k), 32'(br_w[k]), 32'(m_ent[k].br));
          chk($sformatf("u%0d.jump", k), 32'(jp_w[k]), 32'(m_ent[k].jp));
          chk($sformatf("u%0d.illegal", k), 32'(ill_w[k]), 32'(m_ent[k].ill));
          if (m_ent[k].c_imm)
            chk($sformatf("u%0d.imm", k), out_imm_w[k], m_ent[k].imm);
          if (m_ent[k].c_wr)
            chk($sformatf("u%0d.wr_reg", k), 32'(out_wr_w[k]), 32'(m_ent[k].wr));
          if (m_ent[k].c_ctr)
            chk($sformatf("u%0d.alu_ctr", k), 32'(ctr_w[k]), 32'(m_ent[k].ctr));
          if (m_ent[k].c_src)
            chk($sformatf("u%0d.alu_src", k), 32'(src_w[k]), 32'(m_ent[k].src));
        end
      end
    end
  end

  // entered and left 2 time units after a rising edge
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int i = 0; i < 8 && !acc; i++) begin
      #1;
      acc = in_ready_w[0];
      @(posedge clk);
      #2;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=0 want=1");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h0022_1820;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    cmp_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready_w[0]), 32'd0);
    chk("rst_out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("rst_reg_write", 32'(rw_w[0]), 32'd0);
    chk("rst_jump", 32'(jp_w[0]), 32'd0);
    chk("rst_illegal", 32'(ill_w[0]), 32'd0);
    chk("rst_alu_ctr", 32'(ctr_w[0]), 32'd0);
    chk("rst_pc", out_pc_w[0], 32'd0);
    @(posedge clk);
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready_w[0]), 32'd1);

    send(32'h0022_1820, 32'h100);
    chk("add_valid", 32'(out_valid_w[0]), 32'd1);
    chk("add_wr_reg", 32'(out_wr_w[0]), 32'd3);
    chk("add_alu_ctr", 32'(ctr_w[0]), 32'd0);
    chk("add_reg_write", 32'(rw_w[0]), 32'd1);
    chk("add_alu_src", 32'(src_w[0]), 32'd0);

    send(32'h2001_FFFF, 32'h104);
    chk("addi_imm", out_imm_w[0], 32'hFFFF_FFFF);
    send(32'h3001_FFFF, 32'h108);
    chk("andi_imm", out_imm_w[0], 32'h0000_FFFF);
    chk("andi_alu_ctr", 32'(ctr_w[0]), 32'h9);

    send(32'h8C22_0004, 32'h10C);
    in_valid = 1'b1;
    in_instr = 32'h0041_1820;
    in_pc    = 32'h110;
    #1;
    chk("hz_in_ready", 32'(in_ready_w[0]), 32'd0);
    chk("nohz_in_ready", 32'(in_ready_w[1]), 32'd1);
    @(posedge clk);
    #2;
    chk("hz_bubble_valid", 32'(out_valid_w[0]), 32'd0);
    chk("hz_bubble_rw", 32'(rw_w[0]), 32'd0);
    chk("nohz_add_valid", 32'(out_valid_w[1]), 32'd1);
    #1;
    chk("hz_retry_ready", 32'(in_ready_w[0]), 32'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("hz_add_valid", 32'(out_valid_w[0]), 32'd1);
    chk("hz_add_wr_reg", 32'(out_wr_w[0]), 32'd3);

    send(32'h8C20_0004, 32'h114);
    in_valid = 1'b1;
    in_instr = 32'h0000_1820;
    in_pc    = 32'h118;
    #1;
    chk("r0_no_hazard", 32'(in_ready_w[0]), 32'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("r0_add_valid", 32'(out_valid_w[0]), 32'd1);

    send(32'h0800_0010, 32'h1000_0000);
    chk("j_jump", 32'(jp_w[0]), 32'd1);
    chk("j_target", out_jt_w[0], 32'h1000_0040);
    send(32'hFC00_0000, 32'h200);
    chk("ill_flag", 32'(ill_w[0]), 32'd1);
    chk("ill_reg_write", 32'(rw_w[0]), 32'd0);
    chk("ill_mem_write", 32'(mw_w[0]), 32'd0);
    chk("ill_valid", 32'(out_valid_w[0]), 32'd1);
    send(32'h3421_0005, 32'h204);
`ifdef DECODE_EXT_OPS_EN
    chk("ori_illegal", 32'(ill_w[0]), 32'd0);
`else
    chk("ori_illegal", 32'(ill_w[0]), 32'd1);
`endif

    send(32'hAC22_0008, 32'h208);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0022_1820;
    in_pc     = 32'h20C;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready_w[0]), 32'd0);
      @(posedge clk);
      #2;
      chk("stall_pc", out_pc_w[0], 32'h208);
      chk("stall_mem_write", 32'(mw_w[0]), 32'd1);
    end
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready_w[0]), 32'd0);
    @(posedge clk);
    #2;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid_w[0]), 32'd0);
    chk("flush_mem_write", 32'(mw_w[0]), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("flush_not_consumed", 32'(out_valid_w[0]), 32'd0);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
